urv_writeback: RTL and testbench



---
 rtl/urv_writeback.sv | 160 ++++++++++++++++
 tb/tb_urv_writeback.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_writeback.sv
`default_nettype none
// ============================================================================
// Module      : urv_writeback
// Description : uRV writeback stage. Captures execute results, waits for
//               data-memory load completion, extracts and extends the load
//               data, and drives the register-file write port and bypass.
//               Optional load watchdog enabled by URV_WB_LOAD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module urv_writeback #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,

    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,

    output logic        w_stall_o,
    output logic [4:0]  w_rd_o,
    output logic [31:0] w_rd_value_o,
    output logic        w_rd_store_o,
    output logic        w_bypass_rd_write_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_load_timeout_o
);

    localparam logic [2:0] c_FUN_LB  = 3'b000;
    localparam logic [2:0] c_FUN_LH  = 3'b001;
    localparam logic [2:0] c_FUN_LBU = 3'b100;
    localparam logic [2:0] c_FUN_LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [4:0]  r_rd;
    logic [31:0] r_value;
    logic        r_write;
    logic        r_load;
    logic [2:0]  r_fun;
    logic [1:0]  r_addr;

    logic        w_in_wait;
    logic        w_load_done;
    logic        w_expire;
    logic        w_load_end;
    logic        w_capture;
    logic        w_commit;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_end_value;

    assign w_in_wait   = (r_state == LOAD_WAIT);
    // Done strobes outside LOAD_WAIT have no load to complete and are dropped.
    assign w_load_done = w_in_wait && dm_load_done_i;
    assign w_load_end  = w_load_done || w_expire;
    assign w_stall_o   = w_in_wait && !w_load_end;
    assign w_capture   = x_valid_i && !w_stall_o;

`ifdef URV_WB_LOAD_TIMEOUT_EN
    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] c_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;

    // Done takes priority: expiry only fires in a wait cycle without done.
    assign w_expire = w_in_wait && !dm_load_done_i && (r_wait_cnt == c_LAST_WAIT);

    // Watchdog: clears when a load is accepted, counts wait cycles without done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= 8'd0;
        end else if (w_capture && x_load_i) begin
            r_wait_cnt <= 8'd0;
        end else if (w_in_wait && !dm_load_done_i) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    // Without the watchdog the limit has no effect; a load may wait forever.
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign w_expire         = 1'b0;
`endif

    // Load data extraction: pick byte/half by address, then extend by width code.
    always_comb begin
        w_byte = dm_data_l_i[{r_addr, 3'b000} +: 8];
        w_half = r_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
        case (r_fun)
            c_FUN_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_FUN_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_FUN_LBU: w_load_data = {24'd0, w_byte};
            c_FUN_LHU: w_load_data = {16'd0, w_half};
            default:   w_load_data = dm_data_l_i;
        endcase
    end

    // A watchdog expiry commits zero in place of the missing load data.
    assign w_end_value = w_load_done ? w_load_data : 32'd0;

    // Non-load results commit the cycle after capture; loads on done/expiry.
    assign w_commit     = (r_valid && !r_load) || w_load_end;
    assign w_rd_store_o = w_commit && r_write && (r_rd != 5'd0);
    assign w_rd_o       = r_rd;
    assign w_rd_value_o = w_load_end ? w_end_value : r_value;

    assign w_bypass_rd_write_o = w_rd_store_o;
    assign w_bypass_rd_value_o = w_rd_value_o;
    assign w_load_timeout_o    = w_expire;

    // W register and load state: retire the current entry, then capture a new one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_rd    <= 5'd0;
            r_value <= 32'd0;
            r_write <= 1'b0;
            r_load  <= 1'b0;
            r_fun   <= 3'd0;
            r_addr  <= 2'd0;
        end else begin
            if (w_load_end) begin
                // Keep the extracted value visible until the next capture.
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_value <= w_end_value;
            end else if (r_valid && !r_load) begin
                r_valid <= 1'b0;
            end

            if (w_capture) begin
                r_valid <= 1'b1;
                r_rd    <= x_rd_i;
                r_value <= x_rd_value_i;
                r_write <= x_rd_write_i;
                r_load  <= x_load_i;
                r_fun   <= x_fun_i;
                r_addr  <= x_dm_addr_i;
                r_state <= x_load_i ? LOAD_WAIT : IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_urv_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_urv_writeback
// Description : Randomized scoreboard bench for urv_writeback. The driver
//               models the pipeline at instruction level and queues expected
//               register-file writes; a monitor checks outputs each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_urv_writeback;

    localparam int c_TO      = 4;
    localparam int c_WINDOWS = 3000;
    localparam int c_DRAIN   = 40;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        x_valid_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i;
    logic        x_rd_write_i;
    logic        x_load_i;
    logic [2:0]  x_fun_i;
    logic [1:0]  x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        w_stall_o;
    logic [4:0]  w_rd_o;
    logic [31:0] w_rd_value_o;
    logic        w_rd_store_o;
    logic        w_bypass_rd_write_o;
    logic [31:0] w_bypass_rd_value_o;
    logic        w_load_timeout_o;

    always #5 clk = ~clk;

    urv_writeback #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .x_valid_i          (x_valid_i),
        .x_rd_i             (x_rd_i),
        .x_rd_value_i       (x_rd_value_i),
        .x_rd_write_i       (x_rd_write_i),
        .x_load_i           (x_load_i),
        .x_fun_i            (x_fun_i),
        .x_dm_addr_i        (x_dm_addr_i),
        .dm_data_l_i        (dm_data_l_i),
        .dm_load_done_i     (dm_load_done_i),
        .w_stall_o          (w_stall_o),
        .w_rd_o             (w_rd_o),
        .w_rd_value_o       (w_rd_value_o),
        .w_rd_store_o       (w_rd_store_o),
        .w_bypass_rd_write_o(w_bypass_rd_write_o),
        .w_bypass_rd_value_o(w_bypass_rd_value_o),
        .w_load_timeout_o   (w_load_timeout_o)
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    logic        exp_stall   = 1'b0;
    logic        exp_to      = 1'b0;
    logic        chk_zero    = 1'b0;
    logic        mon_en      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Architectural load result: shift the word down, mask, then extend.
    function automatic logic [31:0] load_result(input logic [2:0] fun, input logic [1:0] addr,
                                                input logic [31:0] data);
        int unsigned b;
        int unsigned h;
        b = (data >> (8 * addr)) & 32'hFF;
        h = (data >> (16 * addr[1])) & 32'hFFFF;
        case (fun)
            3'b000:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return data;
        endcase
    endfunction

    // Driver and reference model, one pass per clock window.
    initial begin
        logic        have_ins, in_write, in_load, do_rst, rst_prev;
        logic        pend, done, tmo, draining;
        logic [4:0]  in_rd;
        logic [31:0] in_val;
        logic [2:0]  in_fun;
        logic [1:0]  in_addr;
        logic        ld_pending, ld_write;
        logic [4:0]  ld_rd;
        logic [2:0]  ld_fun;
        logic [1:0]  ld_addr;
        logic [31:0] ld_data;
        int          ld_wait, ld_age;
        logic [2:0]  fun_tab [8];

        fun_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        have_ins = 0; in_write = 0; in_load = 0; in_rd = 0; in_val = 0; in_fun = 0; in_addr = 0;
        ld_pending = 0; ld_write = 0; ld_rd = 0; ld_fun = 0; ld_addr = 0; ld_data = 0;
        ld_wait = 0; ld_age = 0; rst_prev = 1; draining = 0;

        rst_i = 1; x_valid_i = 0; x_rd_i = 0; x_rd_value_i = 0; x_rd_write_i = 0;
        x_load_i = 0; x_fun_i = 0; x_dm_addr_i = 0; dm_data_l_i = 0; dm_load_done_i = 0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;

        for (int n = 0; n < c_WINDOWS + c_DRAIN; n++) begin
            draining = (n >= c_WINDOWS);
            chk_zero = rst_prev;
            do_rst   = ld_pending && !draining && ($urandom_range(0, 40) == 0);
            rst_i    = do_rst;
            rst_prev = do_rst;

            // Memory side.
            pend = ld_pending;
            done = 0;
            tmo  = 0;
            dm_data_l_i    = $urandom;
            dm_load_done_i = 0;
            if (ld_pending) begin
                if (ld_wait == 0 && !do_rst) begin
                    done           = 1;
                    dm_load_done_i = 1;
                    dm_data_l_i    = ld_data;
                end else begin
`ifdef URV_WB_LOAD_TIMEOUT_EN
                    if (ld_age + 1 == c_TO) tmo = 1;
`endif
                    ld_age++;
                    if (ld_wait > 0) ld_wait--;
                end
            end else begin
                dm_load_done_i = ($urandom_range(0, 3) == 0);
            end
            if (done || tmo) begin
                if (ld_write && ld_rd != 0)
                    q.push_back('{cyc, ld_rd, done ? load_result(ld_fun, ld_addr, ld_data) : 32'd0});
                ld_pending = 0;
            end
            exp_stall = pend && !(done || tmo);
            exp_to    = tmo;

            // Execute side.
            if (!have_ins && !draining && $urandom_range(0, 3) != 0) begin
                have_ins = 1;
                in_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                in_val   = $urandom;
                in_write = ($urandom_range(0, 5) != 0);
                in_load  = ($urandom_range(0, 9) < 4);
                in_fun   = fun_tab[$urandom_range(0, 7)];
                in_addr  = 2'($urandom_range(0, 3));
            end
            x_valid_i    = have_ins;
            x_rd_i       = in_rd;
            x_rd_value_i = in_val;
            x_rd_write_i = in_write;
            x_load_i     = in_load;
            x_fun_i      = in_fun;
            x_dm_addr_i  = in_addr;

            if (have_ins && !exp_stall && !do_rst) begin
                have_ins = 0;
                if (in_load) begin
                    ld_pending = 1;
                    ld_age     = 0;
                    ld_wait    = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 4);
                    ld_data    = $urandom;
                    ld_rd      = in_rd;
                    ld_write   = in_write;
                    ld_fun     = in_fun;
                    ld_addr    = in_addr;
                end else if (in_write && in_rd != 0) begin
                    q.push_back('{cyc + 1, in_rd, in_val});
                end
            end
            if (do_rst) ld_pending = 0;

            @(posedge clk);
            #1;
        end

        mon_en = 0;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected writes still queued, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: per-cycle control checks and scoreboard matching of write strobes.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            vectors++;
            if (w_stall_o !== exp_stall) begin
                miscompares++;
                $display("FAIL stall @%0d: got %b required %b", cyc, w_stall_o, exp_stall);
            end
            vectors++;
            if (w_load_timeout_o !== exp_to) begin
                miscompares++;
                $display("FAIL timeout @%0d: got %b required %b", cyc, w_load_timeout_o, exp_to);
            end
            vectors++;
            if (w_bypass_rd_write_o !== w_rd_store_o || w_bypass_rd_value_o !== w_rd_value_o) begin
                miscompares++;
                $display("FAIL bypass @%0d: got %b/%h required %b/%h", cyc,
                         w_bypass_rd_write_o, w_bypass_rd_value_o, w_rd_store_o, w_rd_value_o);
            end
            if (chk_zero) begin
                vectors++;
                if (w_rd_o !== 5'd0 || w_rd_value_o !== 32'd0 || w_rd_store_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_state @%0d: got rd=%0d val=%h store=%b required 0/0/0",
                             cyc, w_rd_o, w_rd_value_o, w_rd_store_o);
                end
            end
            if (w_rd_store_o === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_write @%0d: got rd=%0d val=%h required no write",
                             cyc, w_rd_o, w_rd_value_o);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.rd !== w_rd_o || e.val !== w_rd_value_o) begin
                        miscompares++;
                        $display("FAIL write: got cyc=%0d rd=%0d val=%h required cyc=%0d rd=%0d val=%h",
                                 cyc, w_rd_o, w_rd_value_o, e.cyc, e.rd, e.val);
                    end
                end
            end else if (w_rd_store_o !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL store_x @%0d: got %b required 0 or 1", cyc, w_rd_store_o);
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                e = q.pop_front();
                $display("FAIL missing_write @%0d: got no strobe required rd=%0d val=%h at cyc=%0d",
                         cyc, e.rd, e.val, e.cyc);
            end
        end
    end

endmodule
`default_nettype wire
